// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings
// and the stack-count width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_HOLD   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_t;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack. Only the occupancy counter is reset; stored
// entries are unreachable until the counter covers them again.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4,
  localparam int CW = count_w(STACK_DEPTH),
  localparam int AW = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0]    count_q, count_d, count_m1;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign count_m1 = count_q - CW'(1);
  assign wr_idx   = count_q[AW-1:0];
  assign rd_idx   = count_m1[AW-1:0];

  assign full  = (count_q == CW'(STACK_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign top   = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full)
      count_d = count_q + CW'(1);
    else if (pop && !empty)
      count_d = count_m1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: address register, next-address mux/adder,
// op decode and a one-cycle fault flag for illegal CALL/RET.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STEP        = 1,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter int               STACK_DEPTH = 4,
  localparam int CW = count_w(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] in_bus,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out_address,
  output logic [CW-1:0]    stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             fault
);

  logic [WIDTH-1:0] addr_q, addr_d;
  logic             fault_q, fault_d;
  logic             push, pop;
  logic [WIDTH-1:0] seq_addr, ret_addr;

  assign seq_addr = addr_q + WIDTH'(STEP);
  assign push     = (op == OP_CALL) && !stack_full;
  assign pop      = (op == OP_RET)  && !stack_empty;
  assign fault_d  = ((op == OP_CALL) && stack_full) || ((op == OP_RET) && stack_empty);

  return_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq_addr),
    .top       (ret_addr),
    .count     (stack_count),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Codes 6/7 and rejected CALL/RET fall through to hold the address.
  always_comb begin
    addr_d = addr_q;
    case (op)
      OP_INC:    addr_d = seq_addr;
      OP_JUMP:   addr_d = in_bus;
      OP_BRANCH: addr_d = addr_q + in_bus;  // two's-complement add covers negative offsets
      OP_CALL:   if (push) addr_d = in_bus;
      OP_RET:    if (pop)  addr_d = ret_addr;
      default:   addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      addr_q  <= RESET_ADDR;
      fault_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  assign out_address = addr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random ops against a
// queue-based reference model; a STEP=1 instance covers the unit-step cases.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic [W-1:0]  in_bus;
  logic [2:0]    op;

  logic [W-1:0]  a4, a1;
  logic [CW-1:0] c4, c1;
  logic          fl4, fl1, e4, e1, f4, f1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_addr;
  logic [W-1:0] m_stk[$];
  logic         m_fault;

  pc_sequencer #(.WIDTH(W), .STEP(4), .RESET_ADDR('0), .STACK_DEPTH(D)) dut4 (
    .clk(clk), .n_rst(n_rst), .in_bus(in_bus), .op(op),
    .out_address(a4), .stack_count(c4), .stack_full(fl4),
    .stack_empty(e4), .fault(f4)
  );

  pc_sequencer #(.WIDTH(W), .STEP(1), .RESET_ADDR('0), .STACK_DEPTH(D)) dut1 (
    .clk(clk), .n_rst(n_rst), .in_bus(in_bus), .op(op),
    .out_address(a1), .stack_count(c1), .stack_full(fl1),
    .stack_empty(e1), .fault(f1)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one op for one clock, advances the model, then compares dut4.
  task automatic step(input logic r, input logic [2:0] o, input logic [W-1:0] b);
    n_rst  = r;
    op     = o;
    in_bus = b;
    @(posedge clk);
    #1;
    m_fault = 1'b0;
    if (!r) begin
      m_addr = '0;
      m_stk.delete();
    end else begin
      case (o)
        3'd0: m_addr = m_addr + 4;
        3'd2: m_addr = b;
        3'd3: m_addr = m_addr + b;
        3'd4: if (m_stk.size() == D) m_fault = 1'b1;
              else begin m_stk.push_back(m_addr + 4); m_addr = b; end
        3'd5: if (m_stk.size() == 0) m_fault = 1'b1;
              else m_addr = m_stk.pop_back();
        default: ;
      endcase
    end
    chk("addr",  a4, m_addr);
    chk("count", W'(c4), W'(m_stk.size()));
    chk("full",  W'(fl4), W'(m_stk.size() == D));
    chk("empty", W'(e4), W'(m_stk.size() == 0));
    chk("fault", W'(f4), W'(m_fault));
  endtask

  initial begin
    n_rst = 1'b0; op = OP_HOLD; in_bus = '0;

    // Reset state, both instances
    step(1'b0, OP_CALL, 32'h1234);
    chk("rst_addr1", a1, 32'h0);
    chk("rst_cnt1",  W'(c1), 32'd0);
    chk("rst_emp1",  W'(e1), 32'd1);
    chk("rst_full1", W'(fl1), 32'd0);
    chk("rst_flt1",  W'(f1), 32'd0);

    // Sequential increments for STEP=1 and STEP=4
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, OP_INC, '0);
      chk("inc1", a1, W'(i));
      chk("inc4", a4, W'(4 * i));
    end

    // Negative branch and wrap-around
    step(1'b1, OP_JUMP, 32'h100);
    step(1'b1, OP_BRANCH, 32'hFFFF_FFF0);
    chk("branch1", a1, 32'hF0);
    chk("branch4", a4, 32'hF0);
    step(1'b1, OP_JUMP, 32'hFFFF_FFFF);
    step(1'b1, OP_INC, '0);
    chk("wrap1", a1, 32'h0);
    chk("wrapf1", W'(f1), 32'd0);
    step(1'b1, OP_JUMP, 32'hFFFF_FFFC);
    step(1'b1, OP_INC, '0);
    chk("wrap4", a4, 32'h0);

    // Nested call/return
    step(1'b1, OP_JUMP, 32'h10);
    step(1'b1, OP_CALL, 32'h200);
    chk("call1", a4, 32'h200);
    step(1'b1, OP_CALL, 32'h300);
    chk("call2", a4, 32'h300);
    step(1'b1, OP_RET, '0);
    chk("ret1", a4, 32'h204);
    step(1'b1, OP_RET, '0);
    chk("ret2", a4, 32'h14);

    // Overflow and underflow faults
    for (int i = 0; i < D; i++) step(1'b1, OP_CALL, 32'h1000 + 32'(i * 16));
    step(1'b1, OP_CALL, 32'hDEAD_0000);
    chk("ovf_flt", W'(f4), 32'd1);
    step(1'b1, OP_HOLD, '0);
    for (int i = 0; i < D; i++) step(1'b1, OP_RET, '0);
    step(1'b1, OP_RET, '0);
    chk("udf_flt", W'(f4), 32'd1);
    step(1'b1, OP_INC, '0);

    // Reset overrides a CALL mid-sequence
    step(1'b1, OP_CALL, 32'h400);
    step(1'b1, OP_CALL, 32'h500);
    step(1'b0, OP_CALL, 32'h600);
    chk("rst_mid", a4, 32'h0);

    // Hold-like codes with a non-empty stack
    step(1'b1, OP_CALL, 32'h700);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OP_HOLD, 32'h55);
      step(1'b1, 3'd6, 32'h66);
      step(1'b1, 3'd7, 32'h77);
    end

    // Back-to-back call/return
    step(1'b1, OP_CALL, 32'h800);
    step(1'b1, OP_RET, '0);
    step(1'b1, OP_CALL, 32'h900);
    step(1'b1, OP_RET, '0);

    // Random ops, biased toward stack traffic
    for (int n = 0; n < 400; n++) begin
      logic          r;
      logic [2:0]    o;
      logic [W-1:0]  b;
      int            sel;
      r   = ($urandom_range(0, 49) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 3)      o = OP_CALL;
      else if (sel < 6) o = OP_RET;
      else              o = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 64)) - 32;
      step(r, o, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: address and bus width in bits.
REQ-002 Parameter STEP, default 1: sequential increment amount.
REQ-003 Parameter RESET_ADDR, default 0: address loaded on reset.
REQ-004 Parameter STACK_DEPTH, default 4: return-address stack entries; the legal range is 2..16.
REQ-005 The module SHALL have one clock and a synchronous, active-low reset, with the ports below.
- clk  input  1  rising-edge clock.
- n_rst  input  1  synchronous active-low reset.
- in_bus  input  WIDTH  jump/call target, or signed two's-complement branch offset.
- op  input  3  operation, type pc_op_t.
- out_address  output  WIDTH  current program address, registered.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  high when stack_count == STACK_DEPTH.
- stack_empty  output  1  high when stack_count == 0.
- fault  output  1  registered one-cycle pulse flagging an illegal CALL or RET.

Function
REQ-006 All state SHALL update only on the rising edge of clk; outputs SHALL be registered or decoded from registers only.
REQ-007 The op encoding SHALL be:
- INC=0: out_address <= out_address + STEP.
- HOLD=1: no change.
- JUMP=2: out_address <= in_bus.
- BRANCH=3: out_address <= out_address + in_bus (signed).
- CALL=4: push out_address + STEP, then out_address <= in_bus.
- RET=5: out_address <= top of stack, then pop.
REQ-008 Codes 6 and 7 SHALL behave as HOLD, with fault unaffected.
REQ-009 Arithmetic SHALL be modulo 2^WIDTH; wrap-around is silent and SHALL NOT raise fault.
REQ-010 Latency: the new out_address SHALL be visible one cycle after op is sampled.
REQ-011 CALL with stack_full=1 SHALL leave out_address and the stack unchanged and assert fault for exactly the next cycle.
REQ-012 RET with stack_empty=1 SHALL leave out_address and the stack unchanged and assert fault for exactly the next cycle.
REQ-013 fault SHALL be 0 in every cycle that follows a legal op.
REQ-014 The stack SHALL be LIFO; a RET immediately after a CALL SHALL return that CALL's pushed address.
REQ-015 stack_count, stack_full and stack_empty SHALL reflect the post-edge state in the same cycle as out_address.
REQ-016 Back-to-back CALL/RET on consecutive cycles SHALL be supported with no bubble.

Reset
REQ-017 While n_rst=0 at a rising edge, the block SHALL set out_address=RESET_ADDR, stack_count=0, stack_empty=1, stack_full=0 and fault=0.
REQ-018 Reset SHALL override any op sampled in the same cycle, including CALL/RET mid-sequence.
REQ-019 Stack contents need not be cleared; an entry SHALL be unreachable unless stack_count covers it.
REQ-020 Before the first reset edge, outputs SHALL be treated as undefined.

Structure
REQ-021 Package pc_pkg SHALL hold the pc_op_t enum (3-bit) and its encodings.
REQ-022 The stack SHALL be a sub-module, return_stack (parameters WIDTH and STACK_DEPTH; ports push, pop, push_data, top, count, full, empty; synchronous active-low reset).
REQ-023 pc_sequencer SHALL hold only the address register, next-address mux/adder, fault register and op decode.

Verification
REQ-024 Reset, then 3 cycles of INC with STEP=1 -> out_address 1, 2, 3; with STEP=4 -> 4, 8, 12.
REQ-025 Load 0x100, then BRANCH with in_bus=0xFFFFFFF0 (-16) -> 0xF0; then JUMP with 0xFFFFFFFF followed by INC -> 0x0 with fault=0.
REQ-026 At 0x10, CALL 0x200, then CALL 0x300, then RET, then RET -> out_address 0x200, 0x300, 0x204, 0x14 (STEP=4) with stack_count 1, 2, 1, 0.
REQ-027 Perform STACK_DEPTH CALLs, then one extra CALL -> stack_full=1, one-cycle fault, out_address unchanged; then RET from empty after draining -> one-cycle fault, address held.
REQ-028 Assert n_rst=0 in the same cycle as a CALL with stack_count=2 -> next cycle out_address=RESET_ADDR, stack_count=0, fault=0.
REQ-029 HOLD and op codes 6/7 for 5 cycles -> out_address and stack_count unchanged and fault=0 throughout.
